// File: rtl/bus_fabric.sv
// Single-master to N-slave bus fabric: address decode, write forwarding, and one outstanding
// read with a timeout, error response and a saturating error counter.
module bus_fabric #(
  parameter int unsigned          AW       = 16,
  parameter int unsigned          DW       = 32,
  parameter int unsigned          N        = 4,
  parameter logic [N*AW-1:0]      SLV_BASE = {16'h8000, 16'h5000, 16'h4000, 16'h0000},
  parameter logic [N*AW-1:0]      SLV_MASK = {16'h8000, 16'hF000, 16'hF000, 16'hC000},
  parameter int unsigned          TIMEOUT  = 15,
  parameter logic [31:0]          ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     m_addr,
  input  logic              m_ren,
  input  logic              m_wen,
  input  logic [DW-1:0]     m_wdata,
  input  logic [DW/8-1:0]   m_wmask,
  output logic [DW-1:0]     m_rdata,
  output logic              m_rd_valid,
  output logic              m_busy,
  output logic              m_err,
  output logic [AW-1:0]     s_addr,
  output logic [N-1:0]      s_ren,
  output logic [N-1:0]      s_wen,
  output logic [DW-1:0]     s_wdata,
  output logic [DW/8-1:0]   s_wmask,
  input  logic [N*DW-1:0]   s_rdata,
  input  logic [N-1:0]      s_rd_valid,
  output logic [7:0]        err_count
);

  localparam int unsigned   SW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [DW-1:0] ErrData = DW'(ERR_DATA);
  localparam logic [7:0]    ToLast  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state;
  logic [SW-1:0] sel_q;
  logic [7:0]    cnt_q;

  logic          hit;
  logic [SW-1:0] sel;
  logic [AW-1:0] sel_mask;
  logic          idle;
  logic          req_ok;
  logic          valid_sel;
  logic          valid_lat;
  logic          timeout;
  logic          err_set;

  // Walk from the top index down so the lowest matching slave is the one left standing.
  always_comb begin
    hit      = 1'b0;
    sel      = '0;
    sel_mask = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if ((m_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit      = 1'b1;
        sel      = SW'(i);
        sel_mask = SLV_MASK[i*AW +: AW];
      end
    end
  end

  assign idle      = (state == StIdle);
  assign req_ok    = idle && !rst && (m_ren ^ m_wen) && hit;
  assign valid_sel = s_rd_valid[sel];
  assign valid_lat = s_rd_valid[sel_q];
  assign timeout   = (cnt_q == ToLast);

  assign s_addr  = m_addr & ~sel_mask;
  assign s_wdata = m_wdata;
  assign s_wmask = m_wmask;
  assign m_busy  = !idle;

  always_comb begin
    s_ren = '0;
    s_wen = '0;
    if (req_ok) begin
      s_ren[sel] = m_ren;
      s_wen[sel] = m_wen;
    end
  end

  // Errors: conflicting or unmapped request in IDLE, or a WAIT that runs out without data.
  always_comb begin
    err_set = 1'b0;
    if (idle) begin
      err_set = (m_ren && m_wen) || ((m_ren || m_wen) && !hit);
    end else if (state == StWait) begin
      err_set = timeout && !valid_lat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      sel_q      <= '0;
      cnt_q      <= '0;
      m_rdata    <= '0;
      m_rd_valid <= 1'b0;
      m_err      <= 1'b0;
      err_count  <= '0;
    end else begin
      m_rd_valid <= 1'b0;
      m_err      <= err_set;
      if (err_set && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
      unique case (state)
        StIdle: begin
          if (m_ren && !m_wen) begin
            if (!hit) begin
              state      <= StResp;
              m_rdata    <= ErrData;
              m_rd_valid <= 1'b1;
            end else begin
              sel_q <= sel;
              cnt_q <= '0;
              if (valid_sel) begin
                state      <= StResp;
                m_rdata    <= s_rdata[sel*DW +: DW];
                m_rd_valid <= 1'b1;
              end else begin
                state <= StWait;
              end
            end
          end
        end
        StWait: begin
          if (valid_lat) begin
            state      <= StResp;
            m_rdata    <= s_rdata[sel_q*DW +: DW];
            m_rd_valid <= 1'b1;
          end else if (timeout) begin
            state      <= StResp;
            m_rdata    <= ErrData;
            m_rd_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 SHALL have parameter AW, 16, address width.
REQ-002 SHALL have parameter DW, 32, data width; a multiple of 8.
REQ-003 SHALL have parameter N, 4, slave count (1..8).
REQ-004 SHALL have parameter SLV_BASE, {16'h8000,16'h5000,16'h4000,16'h0000}, N packed AW-bit bases, slave 0 in the LSBs.
REQ-005 SHALL have parameter SLV_MASK, {16'h8000,16'hF000,16'hF000,16'hC000}, N packed AW-bit decode masks.
REQ-006 SHALL have parameter TIMEOUT, 15, maximum number of WAIT cycles (1..255).
REQ-007 SHALL have parameter ERR_DATA, 32'hDEADBEEF, read data returned on error; truncated or zero-extended to DW.
REQ-008 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock, rising edge; rst  in  1  asynchronous active-high reset.
REQ-009 SHALL have master-side ports: m_addr in AW; m_ren in 1 read request; m_wen in 1 write request; m_wdata in DW; m_wmask in DW/8 byte enables; m_rdata out DW; m_rd_valid out 1 one-cycle response strobe; m_busy out 1 read outstanding; m_err out 1 one-cycle error strobe.
REQ-010 SHALL have slave-side ports: s_addr out AW shared offset; s_ren out N; s_wen out N; s_wdata out DW; s_wmask out DW/8; s_rdata in N*DW packed; s_rd_valid in N.
REQ-011 SHALL have output err_count, 8 bits, saturating error counter.

Function
REQ-012 SHALL select slave i when (m_addr & MASK_i) == BASE_i; the lowest matching index wins; no match means unmapped.
REQ-013 SHALL drive s_addr = m_addr & ~MASK_sel, and pass m_wdata and m_wmask combinationally to s_wdata and s_wmask.
REQ-014 SHALL implement a state machine with states IDLE, WAIT and RESP; m_busy = (state != IDLE).
REQ-015 SHALL accept requests only in IDLE; any m_ren or m_wen in WAIT or RESP SHALL be ignored and SHALL NOT be forwarded.
REQ-016 SHALL handle a mapped write in IDLE by driving s_wen[sel]=1 combinationally in the same cycle; the state SHALL stay IDLE.
REQ-017 SHALL handle a mapped read in IDLE by driving s_ren[sel]=1 combinationally in the same cycle, latching sel, clearing the timeout counter and entering WAIT.
REQ-018 SHALL accept s_rd_valid of the selected or latched slave from the request cycle onward; when valid arrives at cycle k (k >= 0), RESP SHALL occur at cycle k+1 with m_rdata registered from that slave's s_rdata and m_rd_valid=1 for exactly one cycle.
REQ-019 SHALL ignore s_rd_valid from any non-latched slave, and any s_rd_valid while in IDLE or RESP.
REQ-020 SHALL time out in WAIT if no valid has arrived by the end of cycle TIMEOUT; RESP SHALL then occur at cycle TIMEOUT+1 with m_rdata=ERR_DATA and m_err=1.
REQ-021 SHALL give valid data priority over timeout when both occur in the same cycle.
REQ-022 SHALL answer an unmapped read with no s_ren, going to RESP at cycle 1 with ERR_DATA and m_err=1.
REQ-023 SHALL answer an unmapped write with no s_wen and m_err=1 at cycle 1.
REQ-024 SHALL treat m_ren and m_wen asserted together in IDLE as a protocol error: nothing forwarded, no state change, m_err=1 at cycle 1.
REQ-025 SHALL transition RESP -> IDLE unconditionally after one cycle; m_rdata SHALL hold its value until the next response.
REQ-026 SHALL increment err_count by one on each m_err pulse, saturating at 255.

Reset
REQ-027 SHALL, while rst=1, immediately set state=IDLE and m_rd_valid, m_err, m_busy, m_rdata and err_count to 0; s_ren and s_wen SHALL be 0.
REQ-028 SHALL, on reset asserted during WAIT, abort the transaction; an s_rd_valid arriving after reset release SHALL produce no response.

Verification
REQ-029 SHALL verify a mapped read: read 0x4004 with slave 1 valid at cycle 2 and data 0x12345678 -> s_ren=0010, s_addr=0x0004, m_rd_valid at cycle 3 with m_rdata=0x12345678.
REQ-030 SHALL verify a write: write 0x8010, wmask 0011 -> s_wen=1000 in the same cycle, s_addr=0x0010, m_busy stays 0.
REQ-031 SHALL verify timeout: read 0x5000 with no valid -> m_busy high for cycles 1..16, m_rd_valid and m_err at cycle 16, m_rdata=0xDEADBEEF, err_count=1.
REQ-032 SHALL verify unmapped access: read 0x6000 -> no s_ren, error response at cycle 1; write 0x7000 -> no s_wen, m_err at cycle 1; err_count +2.
REQ-033 SHALL verify race handling: slave valid exactly at cycle 15 -> data returned, no m_err; slave 2 stray valid during slave 1 WAIT -> ignored; m_ren+m_wen together -> m_err only.
REQ-034 SHALL verify reset: assert rst during WAIT -> outputs 0 immediately; a late s_rd_valid after release -> no m_rd_valid; 300 errors -> err_count=255.
